// File: rtl/and_vec_pkg.sv
// Shared types, constants and golden-response helper for the AND-cell sweep checker.
package and_vec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Tap mask for x^8+x^6+x^5+x^4+1
  localparam logic [7:0] MISR_POLY = 8'hB8;

  // Golden AND-reduction of the low n bits of vec
  function automatic logic exp_resp(input logic [7:0] vec, input int unsigned n);
    logic r;
    r = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < n) r = r & vec[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/and_vec_misr.sv
// 8-bit MISR compacting sampled DUT responses; synchronous clear has priority over shift.
module and_vec_misr
  import and_vec_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       din_i,
  output logic [7:0] sig_o
);

  logic [7:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = {sig_q[6:0], (^(sig_q & MISR_POLY)) ^ din_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/and_vec_gen_chk.sv
// Exhaustive vector generator and response checker for a combinational AND cell.
// Optional MISR signature enabled by defining AND_VEC_MISR_EN.
module and_vec_gen_chk
  import and_vec_pkg::*;
#(
  parameter int unsigned N_IN     = 2,
  parameter int unsigned HOLD_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec_o,
  input  logic            dut_resp_i,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            fail_seen,
  output logic [7:0]      signature
);

  localparam int unsigned     HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0]   HOLD_INIT = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);
  localparam logic [N_IN-1:0] VEC_LAST  = '1;
  localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE   = (N_IN + 1)'(1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ffv_q, ffv_d;
  logic            fs_q, fs_d;

  logic start_acc;
  logic sample;
  logic mismatch;

  assign start_acc = start && (state_q != APPLY);
  assign sample    = (state_q == APPLY) && (hold_q == '0);
  assign mismatch  = dut_resp_i != exp_resp(8'(vec_q), N_IN);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    fs_d    = fs_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_acc) begin
          state_d = APPLY;
          vec_d   = '0;
          hold_d  = HOLD_INIT;
          err_d   = '0;
          ffv_d   = '0;
          fs_d    = 1'b0;
        end
      end
      APPLY: begin
        if (!sample) begin
          hold_d = hold_q - HOLD_ONE;
        end else begin
          if (mismatch) begin
            err_d = err_q + ERR_ONE;
            if (!fs_q) begin
              ffv_d = vec_q;
              fs_d  = 1'b1;
            end
          end
          // All-ones is the terminal vector; the counter never wraps
          if (vec_q == VEC_LAST) begin
            state_d = DONE;
          end else begin
            vec_d  = vec_q + VEC_ONE;
            hold_d = HOLD_INIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      ffv_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      fs_q    <= fs_d;
    end
  end

  assign vec_o          = vec_q;
  assign busy           = (state_q == APPLY);
  assign done           = (state_q == DONE);
  assign pass           = (state_q == DONE) && (err_q == '0);
  assign err_cnt        = err_q;
  assign first_fail_vec = ffv_q;
  assign fail_seen      = fs_q;

`ifdef AND_VEC_MISR_EN
  and_vec_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (start_acc),
    .en_i  (sample),
    .din_i (dut_resp_i),
    .sig_o (signature)
  );
`else
  assign signature = '0;
`endif

endmodule
